// File: rtl/rw_port_ram_arbiter.sv
// Shared scratch RAM front end: independent round-robin arbiters for the read
// and write channels feeding a 1R/1W RAM, with a tagged 2-cycle read return.

// Simple dual-port RAM: registered read, write committed on the clock edge.
// A read and a write to the same word on the same edge return the old word.
module rw_port_ram #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 10,
   parameter string RAM_TYPE   = "auto"
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr_w,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_r,
   output logic [DATA_WIDTH-1:0] data_out
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (RAM_TYPE == "block") begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and registered read port
      always_ff @(posedge clk) begin
         if (we) mem[addr_w] <= data_in;
         data_out <= mem[addr_r];
      end
   end else if (RAM_TYPE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and registered read port
      always_ff @(posedge clk) begin
         if (we) mem[addr_w] <= data_in;
         data_out <= mem[addr_r];
      end
   end else begin : g_auto
      logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and registered read port
      always_ff @(posedge clk) begin
         if (we) mem[addr_w] <= data_in;
         data_out <= mem[addr_r];
      end
   end
endmodule

// Round-robin arbiter: first requester at or after ptr wins; ptr moves past
// the winner. Grant is forced to zero while reset is high.
module rr_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   logic [IW-1:0] ptr;
   logic          found;
   int            idx;

   // Scan requests starting at ptr, wrapping modulo N
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && !reset && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = IW'(idx);
         end
      end
   end

   // Advance priority pointer past the granted port; hold when idle
   always_ff @(posedge clk) begin
      if (reset)      ptr <= '0;
      else if (found) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
   end
endmodule

module rw_port_ram_arbiter #(
   parameter int    NUM_PORTS  = 4,
   parameter int    PORT_BITS  = 2,
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 10,
   parameter string RAM_TYPE   = "auto"
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            rd_req,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_PORTS-1:0]            rd_gnt,
   output logic [NUM_PORTS-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]           rd_data,
   input  logic [NUM_PORTS-1:0]            wr_req,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_PORTS-1:0]            wr_gnt
);
   logic [PORT_BITS-1:0]  rd_idx, wr_idx;
   logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [NUM_PORTS-1:0]  rd_sel_q;
   logic                  we_q;

   rr_arb #(.N(NUM_PORTS), .IW(PORT_BITS)) u_rd_arb (
      .clk(clk), .reset(reset), .req(rd_req), .gnt(rd_gnt), .gnt_idx(rd_idx));

   rr_arb #(.N(NUM_PORTS), .IW(PORT_BITS)) u_wr_arb (
      .clk(clk), .reset(reset), .req(wr_req), .gnt(wr_gnt), .gnt_idx(wr_idx));

   // Read stage 1: capture winner's address and tag; stage 2: tag follows RAM output
   always_ff @(posedge clk) begin
      rd_addr_q <= rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
      if (reset) begin
         rd_sel_q <= '0;
         rd_valid <= '0;
      end else begin
         rd_sel_q <= rd_gnt;
         rd_valid <= rd_sel_q;
      end
   end

   // Write stage: capture winner's address/data; strobe cleared by reset
   always_ff @(posedge clk) begin
      wr_addr_q <= wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_q <= wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
      if (reset) we_q <= 1'b0;
      else       we_q <= |wr_gnt;
   end

   // A write still pending when reset arrives never reaches the array
   rw_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RAM_TYPE(RAM_TYPE)) u_ram (
      .clk(clk), .we(we_q & ~reset), .addr_w(wr_addr_q), .data_in(wr_data_q),
      .addr_r(rd_addr_q), .data_out(rd_data));
endmodule

// File: tb/tb_rw_port_ram_arbiter.sv
// Bench for rw_port_ram_arbiter: directed grant table, ordering/reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_rw_port_ram_arbiter;
   localparam int N  = 4;
   localparam int PB = 2;
   localparam int DW = 32;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
   logic [N*AW-1:0] rd_addr, wr_addr;
   logic [N*DW-1:0] wr_data;
   logic [DW-1:0]   rd_data;

   int checks = 0;
   int errors = 0;

   rw_port_ram_arbiter #(.NUM_PORTS(N), .PORT_BITS(PB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs checked 3 units later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [N-1:0] rr, wr, eg_r, eg_w, ev;
   } vec_t;
   vec_t tbl [19];

   // ---------------- behavioural reference model ----------------
   logic [DW-1:0] mm [0:31];
   int            rptr, wptr, last_gr, last_gw;
   logic [N-1:0]  p1v, p2v;
   logic [DW-1:0] p1d, p2d;

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int i = 0; i < N; i++)
         if (req[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   task automatic model_step();
      logic [N-1:0]  egr, egw, cv;
      logic [DW-1:0] cd;
      int gr, gw;
      gr = rr_pick(rd_req, rptr);
      gw = rr_pick(wr_req, wptr);
      egr = '0; egw = '0; cv = '0; cd = '0;
      if (gr >= 0) egr[gr] = 1'b1;
      if (gw >= 0) egw[gw] = 1'b1;
      chk("rnd_rd_gnt", rd_gnt, egr);
      chk("rnd_wr_gnt", wr_gnt, egw);
      chk("rnd_rd_valid", rd_valid, p2v);
      if (p2v != '0) chk("rnd_rd_data", rd_data, p2d);
      // read sees memory before this cycle's write
      if (gr >= 0) begin
         cv = egr;
         cd = mm[int'(rd_addr[gr*AW +: AW])];
         rptr = (gr + 1) % N;
      end
      if (gw >= 0) begin
         mm[int'(wr_addr[gw*AW +: AW])] = wr_data[gw*DW +: DW];
         wptr = (gw + 1) % N;
      end
      p2v = p1v; p2d = p1d; p1v = cv; p1d = cd;
      last_gr = gr; last_gw = gw;
   endtask

   int           pr [N], pw [N], wt_r [N], wt_w [N];
   logic [AW-1:0] ra [N], wa [N];
   logic [DW-1:0] wd [N];

   initial begin
      //                rd_req   wr_req   rd_gnt   wr_gnt   rd_valid
      tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b0000};
      tbl[1]  = '{4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000};
      tbl[2]  = '{4'b1111, 4'b1111, 4'b0100, 4'b0100, 4'b0001};
      tbl[3]  = '{4'b1111, 4'b1111, 4'b1000, 4'b1000, 4'b0010};
      tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
      tbl[5]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
      tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      tbl[7]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
      tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
      tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      tbl[10] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0000};
      tbl[11] = '{4'b0011, 4'b1001, 4'b0001, 4'b1000, 4'b0000};
      tbl[12] = '{4'b0011, 4'b1001, 4'b0010, 4'b0001, 4'b0010};
      tbl[13] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      tbl[14] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
      tbl[15] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
      tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) tick();
      // reset state: grants suppressed even with requests pending
      rd_req = '1; wr_req = '1;
      #3;
      chk("reset_rd_gnt", rd_gnt, 4'b0000);
      chk("reset_wr_gnt", wr_gnt, 4'b0000);
      chk("reset_rd_valid", rd_valid, 4'b0000);
      tick();
      reset = 1'b0;

      // round-robin sequences, pointer wrap, single requester
      for (int i = 0; i < 19; i++) begin
         rd_req = tbl[i].rr; wr_req = tbl[i].wr;
         #3;
         chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt, tbl[i].eg_r);
         chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt, tbl[i].eg_w);
         chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].ev);
         tick();
      end

      // write then read one cycle later returns new data
      wr_req = 4'b0100; wr_addr[2*AW +: AW] = 10'h005; wr_data[2*DW +: DW] = 32'hDEADBEEF;
      #3 chk("wr_after_gnt", wr_gnt, 4'b0100);
      tick();
      wr_req = '0; rd_req = 4'b0010; rd_addr[1*AW +: AW] = 10'h005;
      #3 chk("rd_after_gnt", rd_gnt, 4'b0010);
      tick();
      rd_req = '0;
      tick();
      #3;
      chk("raw_valid", rd_valid, 4'b0010);
      chk("raw_data", rd_data, 32'hDEADBEEF);
      tick();

      // same-cycle read/write to one address returns old word; next read sees new
      wr_req = 4'b0001; wr_addr[0 +: AW] = 10'h010; wr_data[0 +: DW] = 32'h7;
      tick();
      wr_req = '0;
      repeat (2) tick();
      wr_req = 4'b0001; wr_data[0 +: DW] = 32'h1;
      rd_req = 4'b1000; rd_addr[3*AW +: AW] = 10'h010;
      #3;
      chk("same_rd_gnt", rd_gnt, 4'b1000);
      chk("same_wr_gnt", wr_gnt, 4'b0001);
      tick();
      wr_req = '0;
      tick();
      rd_req = '0;
      #3;
      chk("same_valid", rd_valid, 4'b1000);
      chk("same_old_data", rd_data, 32'h7);
      tick();
      #3;
      chk("next_valid", rd_valid, 4'b1000);
      chk("next_new_data", rd_data, 32'h1);
      tick();

      // reset one cycle after a read grant discards the read and the pending write
      rd_req = 4'b0100; rd_addr[2*AW +: AW] = 10'h010;
      wr_req = 4'b0010; wr_addr[1*AW +: AW] = 10'h010; wr_data[1*DW +: DW] = 32'h55;
      #3;
      chk("rst_pre_rd_gnt", rd_gnt, 4'b0100);
      chk("rst_pre_wr_gnt", wr_gnt, 4'b0010);
      tick();
      reset = 1'b1; rd_req = '1; wr_req = '0;
      #3 chk("rst_mid_rd_gnt", rd_gnt, 4'b0000);
      tick();
      reset = 1'b0; rd_addr[0 +: AW] = 10'h010;
      #3;
      chk("rst_no_valid", rd_valid, 4'b0000);
      chk("rst_first_gnt", rd_gnt, 4'b0001);
      tick();
      rd_req = '0;
      #3 chk("rst_no_valid2", rd_valid, 4'b0000);
      tick();
      #3;
      chk("rst_post_valid", rd_valid, 4'b0001);
      chk("rst_write_dropped", rd_data, 32'h1);
      tick();

      // ---------------- randomized traffic vs model ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rptr = 0; wptr = 0; p1v = '0; p2v = '0; p1d = '0; p2d = '0;
      for (int a = 0; a < 32; a++) begin
         rd_req = '0; wr_req = 4'b0001;
         wr_addr[0 +: AW] = AW'(a); wr_data[0 +: DW] = $urandom;
         #3 model_step();
         tick();
      end
      for (int p = 0; p < N; p++) begin pr[p] = 0; pw[p] = 0; end
      for (int c = 0; c < 10000; c++) begin
         for (int p = 0; p < N; p++) begin
            if (pr[p] == 0 && $urandom_range(0, 2) == 0) begin
               pr[p] = 1; wt_r[p] = 0; ra[p] = AW'($urandom_range(0, 31));
            end
            if (pw[p] == 0 && $urandom_range(0, 2) == 0) begin
               pw[p] = 1; wt_w[p] = 0; wa[p] = AW'($urandom_range(0, 31)); wd[p] = $urandom;
            end
            rd_req[p] = (pr[p] != 0); rd_addr[p*AW +: AW] = ra[p];
            wr_req[p] = (pw[p] != 0); wr_addr[p*AW +: AW] = wa[p]; wr_data[p*DW +: DW] = wd[p];
         end
         #3 model_step();
         for (int p = 0; p < N; p++) begin
            if (pr[p] != 0) begin
               if (last_gr == p) pr[p] = 0;
               else begin
                  wt_r[p]++;
                  chk($sformatf("rd_starve_p%0d", p), wt_r[p] < N, 1);
               end
            end
            if (pw[p] != 0) begin
               if (last_gw == p) pw[p] = 0;
               else begin
                  wt_w[p]++;
                  chk($sformatf("wr_starve_p%0d", p), wt_w[p] < N, 1);
               end
            end
         end
         tick();
      end
      rd_req = '0; wr_req = '0;
      repeat (3) begin
         #3 model_step();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
